regfile_onehot_wr: RTL and testbench
====================================

Name: regfile_onehot_wr

Overview:
- 32-entry general-purpose register file.
- It sits directly downstream of the 5-to-32 write-address decoder and consumes that decoder's 32-bit one-hot write-enable vector.
- Writes are synchronous; the two read ports are combinational and feed the ALU operand path.
- It checks the one-hot integrity of the write vector and keeps a sticky error flag for debug.

Parameters:
- WIDTH, 32: data width of each register in bits.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero; writes to it are ignored and reads of it return 0.
- BYPASS, 1: when 1, a read of the register being written this cycle returns wdata (write-through); when 0, the read returns the stored value.

Ports:
- clk, input, 1: the only clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous reset, active low.
- we_onehot, input, 32: write enable, one-hot, taken straight from the decoder output. All zeros means no write.
- wdata, input, WIDTH: write data.
- ra_addr, input, 5: read port A address.
- rb_addr, input, 5: read port B address.
- err_clr, input, 1: synchronous clear of onehot_err.
- ra_data, output, WIDTH: read port A data (combinational).
- rb_data, output, WIDTH: read port B data (combinational).
- onehot_err, output, 1: sticky flag; set when more than one bit of we_onehot is asserted.

Behaviour:
- Reset:
  - While reset_n=0, all 32 registers are forced to 0 and onehot_err=0, independent of clk.
  - No write occurs at any edge while reset_n=0.
  - Reset asserted mid-stream discards any write presented on that edge.
- Write classification, per rising edge, on the population count of we_onehot:
  - Zero bits set: idle, no state change.
  - Exactly one bit i set: reg[i] <= wdata. Exception: i=0 with ZERO_REG=1 is a no-op.
  - Two or more bits set: illegal. No register is written (the write is dropped, not partially applied), and onehot_err <= 1.
- Error flag:
  - onehot_err holds its value until err_clr=1 at a rising edge.
  - If an illegal vector and err_clr=1 occur on the same edge, set wins: onehot_err stays 1.
  - err_clr has no effect on register contents.
- Read ports:
  - Purely combinational; zero-cycle latency from address to data.
  - ra_data = reg[ra_addr], and likewise for port B.
  - Address 0 with ZERO_REG=1 always returns 0, including during a write of register 0.
  - Both ports may read the same address simultaneously.
- Bypass (BYPASS=1):
  - Applies when the current-cycle write is legal (exactly one bit set), targets register i, i equals the read address, and the target is not the hardwired zero.
  - In that case the read data is wdata in the same cycle.
  - Illegal or idle vectors never bypass.
- Bypass disabled (BYPASS=0): a written value is visible from the cycle after the write edge.
- Bit mapping: bit k of we_onehot selects register k, matching the decoder's select=k to out bit k mapping.

Test Plan:
- Reset: pulse reset_n low between edges → all reads 0 and onehot_err=0 immediately, without waiting for a clock edge.
- Single write, then read:
  - we_onehot=32'h0000_0020, wdata=32'hDEAD_BEEF, one edge.
  - Then set we_onehot=0, ra_addr=5 → ra_data=32'hDEAD_BEEF.
  - rb_addr=4 in the same cycle → rb_data=0.
- Zero register (ZERO_REG=1):
  - we_onehot=32'h0000_0001, wdata=32'hFFFF_FFFF.
  - ra_addr=0 → ra_data=0 both before and after the edge.
- Bypass (BYPASS=1):
  - we_onehot=32'h8000_0000, wdata=32'h1234_5678, ra_addr=31, before the edge → ra_data=32'h1234_5678.
  - With BYPASS=0 and the register previously 0, the same stimulus gives ra_data=0 before the edge and 32'h1234_5678 after it.
- Illegal vector:
  - Preload reg3=32'hA and reg7=32'hB.
  - Apply we_onehot=32'h0000_0088, wdata=32'hC, one edge → reg3=32'hA, reg7=32'hB unchanged, onehot_err=1.
  - Next edge with err_clr=1 and a legal vector → onehot_err=0.
  - An illegal vector together with err_clr=1 on one edge → onehot_err remains 1.
- Reset mid-write:
  - Hold we_onehot=32'h0000_0004, wdata=32'h55.
  - Assert reset_n=0 across a rising edge, then release → reg2 reads 0.

Source files
------------

// File: rtl/regfile_onehot_wr.sv
// 32-entry register file written through a one-hot enable vector from the address decoder.
// Two combinational read ports with optional write-through; sticky flag for multi-hot vectors.
module regfile_onehot_wr #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      we_onehot,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       ra_addr,
  input  logic [4:0]       rb_addr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             onehot_err
);

  logic [WIDTH-1:0] regs [32];
  logic             multi_hot;
  logic             single_hot;

  // v & (v-1) clears the lowest set bit; anything left means two or more bits were set
  assign multi_hot  = |(we_onehot & (we_onehot - 32'd1));
  assign single_hot = (|we_onehot) & ~multi_hot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 32; k++) begin
        regs[k] <= '0;
      end
      onehot_err <= 1'b0;
    end else begin
      if (multi_hot) begin
        onehot_err <= 1'b1;
      end else if (err_clr) begin
        onehot_err <= 1'b0;
      end
      for (int k = 0; k < 32; k++) begin
        if (single_hot && we_onehot[k] && !(ZERO_REG && k == 0)) begin
          regs[k] <= wdata;
        end
      end
    end
  end

  always_comb begin
    ra_data = regs[ra_addr];
    if (BYPASS && single_hot && we_onehot[ra_addr]) begin
      ra_data = wdata;
    end
    if (ZERO_REG && ra_addr == 5'd0) begin
      ra_data = '0;
    end
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (BYPASS && single_hot && we_onehot[rb_addr]) begin
      rb_data = wdata;
    end
    if (ZERO_REG && rb_addr == 5'd0) begin
      rb_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Bench for regfile_onehot_wr: write-through and registered-read instances share stimulus,
// checked against an array model with directed and random steps.
module tb_regfile_onehot_wr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] we_onehot;
  logic [31:0] wdata;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic        err_clr;
  logic [31:0] ra_data, rb_data, ra_nb, rb_nb;
  logic        onehot_err, err_nb;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];
  logic        merr;

  regfile_onehot_wr #(.WIDTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .we_onehot(we_onehot), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .err_clr(err_clr),
    .ra_data(ra_data), .rb_data(rb_data), .onehot_err(onehot_err)
  );

  regfile_onehot_wr #(.WIDTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .we_onehot(we_onehot), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .err_clr(err_clr),
    .ra_data(ra_nb), .rb_data(rb_nb), .onehot_err(err_nb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && $countones(we_onehot) == 1 && we_onehot[a]) return wdata;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    merr = 1'b0;
  endtask

  task automatic model_edge();
    int pc;
    pc = $countones(we_onehot);
    if (pc > 1) merr = 1'b1;
    else if (err_clr) merr = 1'b0;
    if (pc == 1) begin
      for (int i = 1; i < 32; i++) begin
        if (we_onehot[i]) model[i] = wdata;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_ra"},    ra_data, exp_rd(ra_addr, 1'b1));
    chk({ph, "_rb"},    rb_data, exp_rd(rb_addr, 1'b1));
    chk({ph, "_ra_nb"}, ra_nb,   exp_rd(ra_addr, 1'b0));
    chk({ph, "_rb_nb"}, rb_nb,   exp_rd(rb_addr, 1'b0));
    chk({ph, "_err"},    {31'd0, onehot_err}, {31'd0, merr});
    chk({ph, "_err_nb"}, {31'd0, err_nb},     {31'd0, merr});
  endtask

  task automatic cycle(input logic [31:0] we, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    @(negedge clk);
    we_onehot = we; wdata = wd; ra_addr = ra; rb_addr = rb; err_clr = clr;
    #1 check_all("pre");
    @(posedge clk);
    model_edge();
    #1 check_all("post");
  endtask

  initial begin
    logic [31:0] we_r;
    int          b1, b2, tgt;

    reset_n = 1'b0; we_onehot = '0; wdata = '0; ra_addr = '0; rb_addr = '0; err_clr = 1'b0;
    model_clear();
    #12;
    chk("rst_ra", ra_data, 32'd0);
    chk("rst_err", {31'd0, onehot_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single write then read, neighbour stays zero
    cycle(32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd4, 1'b0);
    cycle(32'h0, 32'h0, 5'd5, 5'd4, 1'b0);
    chk("wr5_ra", ra_data, 32'hDEAD_BEEF);
    chk("wr5_rb", rb_data, 32'd0);

    // hardwired zero register, checked before and after the edge
    cycle(32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0);
    chk("zero_after", ra_data, 32'd0);

    // write-through vs registered read on register 31
    @(negedge clk);
    we_onehot = 32'h8000_0000; wdata = 32'h1234_5678; ra_addr = 5'd31; rb_addr = 5'd31;
    #1;
    chk("byp_pre", ra_data, 32'h1234_5678);
    chk("nobyp_pre", ra_nb, 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    chk("nobyp_post", ra_nb, 32'h1234_5678);
    check_all("byp");

    // multi-hot vector is dropped and sets the sticky flag
    cycle(32'h0000_0008, 32'hA, 5'd3, 5'd7, 1'b0);
    cycle(32'h0000_0080, 32'hB, 5'd3, 5'd7, 1'b0);
    cycle(32'h0000_0088, 32'hC, 5'd3, 5'd7, 1'b0);
    chk("ill_r3", ra_data, 32'hA);
    chk("ill_r7", rb_data, 32'hB);
    chk("ill_err", {31'd0, onehot_err}, 32'd1);
    cycle(32'h0000_0002, 32'h77, 5'd1, 5'd3, 1'b0);
    chk("err_sticky", {31'd0, onehot_err}, 32'd1);
    cycle(32'h0000_0002, 32'h99, 5'd1, 5'd3, 1'b1);
    chk("err_clr", {31'd0, onehot_err}, 32'd0);
    cycle(32'h0000_0088, 32'hC, 5'd3, 5'd7, 1'b1);
    chk("set_wins", {31'd0, onehot_err}, 32'd1);
    chk("set_wins_r7", rb_data, 32'hB);

    // random traffic: idle, one-hot and two-hot vectors with occasional clears
    for (int n = 0; n < 400; n++) begin
      tgt = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       we_r = 32'd0;
        1, 2:    we_r = 32'd1 << tgt;
        default: begin
          b1 = tgt;
          b2 = (b1 + 1 + $urandom_range(0, 30)) % 32;
          we_r = (32'd1 << b1) | (32'd1 << b2);
        end
      endcase
      cycle(we_r, $urandom,
            ($urandom_range(0, 1) == 1) ? 5'(tgt) : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0));
    end

    // asynchronous reset pulse between edges clears everything at once
    cycle(32'h0000_0300, 32'h1, 5'd5, 5'd9, 1'b0);
    @(negedge clk);
    we_onehot = '0; err_clr = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("arst_err", {31'd0, onehot_err}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i); rb_addr = 5'(31 - i);
      #1;
      chk("arst_ra", ra_data, 32'd0);
      chk("arst_rb", rb_nb, 32'd0);
    end
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;

    // reset held across an edge with a write pending
    cycle(32'h0000_0010, 32'h66, 5'd4, 5'd4, 1'b0);
    @(negedge clk);
    we_onehot = 32'h0000_0004; wdata = 32'h55;
    #2 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_clear();
    reset_n = 1'b1; we_onehot = '0; ra_addr = 5'd2; rb_addr = 5'd4;
    #1;
    chk("rstwr_r2", ra_data, 32'd0);
    chk("rstwr_r4", rb_data, 32'd0);
    cycle(32'h0, 32'h0, 5'd2, 5'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
